// File: rtl/dcache_port0_arbiter.sv
// Write-port-0 arbiter for the data cache: grants whole bursts to the load unit (LDU) or store unit (STU).
// Optional STU aging priority is enabled with `define DCACHE_PORT0_ARBITER_AGING_EN.
module dcache_port0_arbiter #(
  parameter int PORT_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int ENABLE_WIDTH = 4,
  parameter int WAYS_NUMBER  = 4,
  parameter int AGE_LIMIT    = 8,
  localparam int CMD_WIDTH   = 2 + ENABLE_WIDTH + WAYS_NUMBER + ADDR_WIDTH + PORT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 ldu_req_i,
  input  logic                 ldu_last_i,
  input  logic [CMD_WIDTH-1:0] ldu_cmd_i,
  output logic                 ldu_grant_o,
  input  logic                 stu_req_i,
  input  logic                 stu_last_i,
  input  logic [CMD_WIDTH-1:0] stu_cmd_i,
  output logic                 stu_grant_o,
  output logic                 cache_write_o,
  output logic [CMD_WIDTH-1:0] cache_cmd_o,
  output logic                 port0_idle_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] OWN_LDU = 2'd1;
  localparam logic [1:0] OWN_STU = 2'd2;

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       stu_aged_s;

`ifdef DCACHE_PORT0_ARBITER_AGING_EN
  localparam int AGE_W = $clog2(AGE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

  logic [AGE_W-1:0] age_q;
  logic [AGE_W-1:0] age_d;

  assign stu_aged_s = (age_q == AGE_MAX);

  // Count STU waiting cycles; cleared on the cycle the STU grant rises.
  always_comb begin
    age_d = age_q;
    if ((state_d == OWN_STU) && (state_q != OWN_STU)) begin
      age_d = '0;
    end else if (stu_req_i && (state_q != OWN_STU) && !stu_aged_s) begin
      age_d = age_q + AGE_W'(1);
    end else begin
      age_d = age_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end
`else
  assign stu_aged_s = 1'b0;
`endif

  // Next owner. On release the other requester is preferred so LDU cannot lock out STU.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (stu_req_i && (!ldu_req_i || stu_aged_s)) begin
          state_d = OWN_STU;
        end else if (ldu_req_i) begin
          state_d = OWN_LDU;
        end else begin
          state_d = IDLE;
        end
      end
      OWN_LDU: begin
        if (!ldu_req_i || ldu_last_i) begin
          state_d = stu_req_i ? OWN_STU : IDLE;
        end else begin
          state_d = OWN_LDU;
        end
      end
      OWN_STU: begin
        if (!stu_req_i || stu_last_i) begin
          state_d = ldu_req_i ? OWN_LDU : IDLE;
        end else begin
          state_d = OWN_STU;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign ldu_grant_o  = (state_q == OWN_LDU);
  assign stu_grant_o  = (state_q == OWN_STU);
  assign port0_idle_o = (state_q == IDLE);

  // Owner's command passes straight through; a dropped req means no write that cycle.
  always_comb begin
    cache_write_o = 1'b0;
    cache_cmd_o   = '0;
    case (state_q)
      OWN_LDU: begin
        cache_write_o = ldu_req_i;
        cache_cmd_o   = ldu_cmd_i;
      end
      OWN_STU: begin
        cache_write_o = stu_req_i;
        cache_cmd_o   = stu_cmd_i;
      end
      default: begin
        cache_write_o = 1'b0;
        cache_cmd_o   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_port0_arbiter.sv
// Directed self-checking bench for dcache_port0_arbiter.
// Vector word: {ldu_req,ldu_last,stu_req,stu_last, exp{lgrant,sgrant,write,idle}, ldu_data[7:0], stu_data[7:0]}.
module tb_dcache_port0_arbiter;

  localparam int CMD_W = 74;

  logic             clk_i = 1'b0;
  logic             rst_n_i = 1'b0;
  logic             ldu_req_i = 1'b0;
  logic             ldu_last_i = 1'b0;
  logic [CMD_W-1:0] ldu_cmd_i = '0;
  logic             ldu_grant_o;
  logic             stu_req_i = 1'b0;
  logic             stu_last_i = 1'b0;
  logic [CMD_W-1:0] stu_cmd_i = '0;
  logic             stu_grant_o;
  logic             cache_write_o;
  logic [CMD_W-1:0] cache_cmd_o;
  logic             port0_idle_o;

  int n_cmp = 0;
  int n_err = 0;

  dcache_port0_arbiter dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .ldu_req_i     (ldu_req_i),
    .ldu_last_i    (ldu_last_i),
    .ldu_cmd_i     (ldu_cmd_i),
    .ldu_grant_o   (ldu_grant_o),
    .stu_req_i     (stu_req_i),
    .stu_last_i    (stu_last_i),
    .stu_cmd_i     (stu_cmd_i),
    .stu_grant_o   (stu_grant_o),
    .cache_write_o (cache_write_o),
    .cache_cmd_o   (cache_cmd_o),
    .port0_idle_o  (port0_idle_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [CMD_W-1:0] mk_cmd(input logic [7:0] d);
    return {1'b1, 1'b0, 4'b1011, 4'b0100, 24'hA500_00, d, 24'h00_0000, d};
  endfunction

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    rst_n_i = 1'b0;
    next_cycle();
    #1;
    obs = {ldu_grant_o, stu_grant_o, cache_write_o, port0_idle_o};
    n_cmp++;
    if (obs !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_hold: got %b want %b", obs, 4'b0001);
    end
    rst_n_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      #1;
      obs = {ldu_grant_o, stu_grant_o, cache_write_o, port0_idle_o};
      n_cmp++;
      if (obs !== 4'b0001 || cache_cmd_o !== '0) begin
        n_err++;
        $display("FAIL reset_idle cyc %0d: got %b cmd %h want 0001 cmd 0", c, obs, cache_cmd_o);
      end
    end
  endtask

  task automatic test_ldu_burst();
    logic [23:0] vec [6] = '{24'h81_A0_00, 24'h8A_A0_00, 24'h8A_A1_00, 24'h8A_A2_00,
                             24'hCA_A3_00, 24'h01_00_00};
    logic [3:0] obs, exp;
    logic [7:0] ld, sd;
    logic [CMD_W-1:0] exp_cmd;
    int writes = 0;
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      {ldu_req_i, ldu_last_i, stu_req_i, stu_last_i, exp, ld, sd} = vec[c];
      ldu_cmd_i = mk_cmd(ld);
      stu_cmd_i = mk_cmd(sd);
      #1;
      obs = {ldu_grant_o, stu_grant_o, cache_write_o, port0_idle_o};
      exp_cmd = exp[3] ? mk_cmd(ld) : (exp[2] ? mk_cmd(sd) : '0);
      if (cache_write_o === 1'b1) writes++;
      n_cmp++;
      if (obs !== exp || cache_cmd_o !== exp_cmd) begin
        n_err++;
        $display("FAIL ldu_burst cyc %0d: got %b cmd %h want %b cmd %h", c, obs, cache_cmd_o, exp, exp_cmd);
      end
    end
    n_cmp++;
    if (writes != 4) begin
      n_err++;
      $display("FAIL ldu_burst_writes: got %0d want 4", writes);
    end
  endtask

  task automatic test_simultaneous();
    logic [23:0] vec [5] = '{24'hB1_B0_55, 24'hBA_B0_55, 24'hFA_B1_55, 24'h36_00_55, 24'h01_00_00};
    logic [3:0] obs, exp;
    logic [7:0] ld, sd;
    logic [CMD_W-1:0] exp_cmd;
    int stu_writes = 0;
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      {ldu_req_i, ldu_last_i, stu_req_i, stu_last_i, exp, ld, sd} = vec[c];
      ldu_cmd_i = mk_cmd(ld);
      stu_cmd_i = mk_cmd(sd);
      #1;
      obs = {ldu_grant_o, stu_grant_o, cache_write_o, port0_idle_o};
      exp_cmd = exp[3] ? mk_cmd(ld) : (exp[2] ? mk_cmd(sd) : '0);
      if (cache_write_o === 1'b1 && cache_cmd_o === mk_cmd(8'h55)) stu_writes++;
      n_cmp++;
      if (obs !== exp || cache_cmd_o !== exp_cmd) begin
        n_err++;
        $display("FAIL simultaneous cyc %0d: got %b cmd %h want %b cmd %h", c, obs, cache_cmd_o, exp, exp_cmd);
      end
    end
    n_cmp++;
    if (stu_writes != 1) begin
      n_err++;
      $display("FAIL simultaneous_stu_writes: got %0d want 1", stu_writes);
    end
  endtask

  task automatic test_abort();
    logic [23:0] vec [6] = '{24'hB1_C0_66, 24'hBA_C0_66, 24'hBA_C1_66, 24'h38_C2_66,
                             24'h36_00_66, 24'h01_00_00};
    logic [3:0] obs, exp;
    logic [7:0] ld, sd;
    logic [CMD_W-1:0] exp_cmd;
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      {ldu_req_i, ldu_last_i, stu_req_i, stu_last_i, exp, ld, sd} = vec[c];
      ldu_cmd_i = mk_cmd(ld);
      stu_cmd_i = mk_cmd(sd);
      #1;
      obs = {ldu_grant_o, stu_grant_o, cache_write_o, port0_idle_o};
      exp_cmd = exp[3] ? mk_cmd(ld) : (exp[2] ? mk_cmd(sd) : '0);
      n_cmp++;
      if (obs !== exp || cache_cmd_o !== exp_cmd) begin
        n_err++;
        $display("FAIL abort cyc %0d: got %b cmd %h want %b cmd %h", c, obs, cache_cmd_o, exp, exp_cmd);
      end
    end
  endtask

  task automatic test_stu_then_ldu();
    logic [23:0] vec [5] = '{24'h21_00_D0, 24'hE6_E0_D0, 24'hF6_E0_D1, 24'hCA_E0_00, 24'h01_00_00};
    logic [3:0] obs, exp;
    logic [7:0] ld, sd;
    logic [CMD_W-1:0] exp_cmd;
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      {ldu_req_i, ldu_last_i, stu_req_i, stu_last_i, exp, ld, sd} = vec[c];
      ldu_cmd_i = mk_cmd(ld);
      stu_cmd_i = mk_cmd(sd);
      #1;
      obs = {ldu_grant_o, stu_grant_o, cache_write_o, port0_idle_o};
      exp_cmd = exp[3] ? mk_cmd(ld) : (exp[2] ? mk_cmd(sd) : '0);
      n_cmp++;
      if (obs !== exp || cache_cmd_o !== exp_cmd) begin
        n_err++;
        $display("FAIL stu_then_ldu cyc %0d: got %b cmd %h want %b cmd %h", c, obs, cache_cmd_o, exp, exp_cmd);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] vec [5] = '{24'hC1_F0_00, 24'hFA_F0_77, 24'hF6_F1_77, 24'hCA_F1_00, 24'h01_00_00};
    logic [3:0] obs, exp;
    logic [7:0] ld, sd;
    logic [CMD_W-1:0] exp_cmd;
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      {ldu_req_i, ldu_last_i, stu_req_i, stu_last_i, exp, ld, sd} = vec[c];
      ldu_cmd_i = mk_cmd(ld);
      stu_cmd_i = mk_cmd(sd);
      #1;
      obs = {ldu_grant_o, stu_grant_o, cache_write_o, port0_idle_o};
      exp_cmd = exp[3] ? mk_cmd(ld) : (exp[2] ? mk_cmd(sd) : '0);
      n_cmp++;
      if (obs !== exp || cache_cmd_o !== exp_cmd) begin
        n_err++;
        $display("FAIL back_to_back cyc %0d: got %b cmd %h want %b cmd %h", c, obs, cache_cmd_o, exp, exp_cmd);
      end
    end
  endtask

`ifdef DCACHE_PORT0_ARBITER_AGING_EN
  task automatic test_aging();
    logic [23:0] vec [12] = '{24'hB1_10_88, 24'hBA_10_88, 24'hBA_11_88, 24'hBA_12_88,
                              24'hBA_13_88, 24'hBA_14_88, 24'hBA_15_88, 24'hBA_16_88,
                              24'hBA_17_88, 24'hFA_18_88, 24'h36_00_88, 24'h01_00_00};
    logic [3:0] obs, exp;
    logic [7:0] ld, sd;
    logic [CMD_W-1:0] exp_cmd;
    for (int c = 0; c < 12; c++) begin
      next_cycle();
      {ldu_req_i, ldu_last_i, stu_req_i, stu_last_i, exp, ld, sd} = vec[c];
      ldu_cmd_i = mk_cmd(ld);
      stu_cmd_i = mk_cmd(sd);
      #1;
      obs = {ldu_grant_o, stu_grant_o, cache_write_o, port0_idle_o};
      exp_cmd = exp[3] ? mk_cmd(ld) : (exp[2] ? mk_cmd(sd) : '0);
      n_cmp++;
      if (obs !== exp || cache_cmd_o !== exp_cmd) begin
        n_err++;
        $display("FAIL aging cyc %0d: got %b cmd %h want %b cmd %h", c, obs, cache_cmd_o, exp, exp_cmd);
      end
      if (c == 9 || c == 10) begin
        n_cmp++;
        if (int'(dut.age_q) != ((c == 9) ? 8 : 0)) begin
          n_err++;
          $display("FAIL aging_counter cyc %0d: got %0d want %0d", c, dut.age_q, (c == 9) ? 8 : 0);
        end
      end
    end
  endtask
`endif

  task automatic test_async_reset();
    logic [23:0] vec [3] = '{24'h81_90_00, 24'h8A_90_00, 24'h8A_91_00};
    logic [3:0] obs, exp;
    logic [7:0] ld, sd;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      {ldu_req_i, ldu_last_i, stu_req_i, stu_last_i, exp, ld, sd} = vec[c];
      ldu_cmd_i = mk_cmd(ld);
      stu_cmd_i = mk_cmd(sd);
      #1;
      obs = {ldu_grant_o, stu_grant_o, cache_write_o, port0_idle_o};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL async_reset_pre cyc %0d: got %b want %b", c, obs, exp);
      end
    end
    #1;
    rst_n_i = 1'b0;
    #1;
    obs = {ldu_grant_o, stu_grant_o, cache_write_o, port0_idle_o};
    n_cmp++;
    if (obs !== 4'b0001 || cache_cmd_o !== '0) begin
      n_err++;
      $display("FAIL async_reset_now: got %b cmd %h want 0001 cmd 0", obs, cache_cmd_o);
    end
    next_cycle();
    obs = {ldu_grant_o, stu_grant_o, cache_write_o, port0_idle_o};
    n_cmp++;
    if (obs !== 4'b0001) begin
      n_err++;
      $display("FAIL async_reset_held: got %b want 0001", obs);
    end
    ldu_req_i = 1'b0;
    rst_n_i = 1'b1;
    next_cycle();
    obs = {ldu_grant_o, stu_grant_o, cache_write_o, port0_idle_o};
    n_cmp++;
    if (obs !== 4'b0001) begin
      n_err++;
      $display("FAIL async_reset_after: got %b want 0001", obs);
    end
  endtask

  initial begin
    test_reset();
    test_ldu_burst();
    test_simultaneous();
    test_abort();
    test_stu_then_ldu();
    test_back_to_back();
`ifdef DCACHE_PORT0_ARBITER_AGING_EN
    test_aging();
`endif
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
